// File: rtl/mips_pkg.sv
// Shared pipeline-control definitions: controller state encoding, default memory timeout, helpers.
// Pure declarations, no timing or flow-control behaviour of its own.
package mips_pkg;

   localparam logic [1:0] ST_RUN      = 2'd0;
   localparam logic [1:0] ST_MEM_WAIT = 2'd1;
   localparam logic [1:0] ST_ERROR    = 2'd2;

   localparam int         MEM_TIMEOUT_DFLT = 16;
   localparam logic [4:0] REG_ZERO         = 5'd0;

   // Event counters stick at all-ones instead of wrapping.
   function automatic logic [15:0] sat_inc16(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

endpackage

// File: rtl/load_use_detect.sv
// Load-use comparator: purely combinational, 0 cycles.
// Never stalls by itself; pipeline_ctrl decides whether the result takes effect.
module load_use_detect
   import mips_pkg::*;
(
   input  logic       i_idex_memread,
   input  logic [4:0] i_idex_rt,
   input  logic [4:0] i_ifid_rs,
   input  logic [4:0] i_ifid_rt,
   output logic       o_load_use
);

   // $zero is never a real producer, so a load targeting it cannot create a hazard.
   assign o_load_use = i_idex_memread && (i_idex_rt != REG_ZERO) &&
                       ((i_idex_rt == i_ifid_rs) || (i_idex_rt == i_ifid_rt));

endmodule

// File: rtl/pipeline_ctrl.sv
// Hazard/stall controller: combinational enables (0-cycle), memory-wait FSM with sticky timeout.
// Freeze beats load-use beats branch flush; PIPE_PERF_CNT_EN adds saturating stall/flush counters.
module pipeline_ctrl
   import mips_pkg::*;
#(
   parameter int MEM_TIMEOUT = MEM_TIMEOUT_DFLT
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        IDEX_MemRead,
   input  logic [4:0]  IDEX_Rt,
   input  logic [4:0]  IFID_Rs,
   input  logic [4:0]  IFID_Rt,
   input  logic        branch_taken,
   input  logic        dmem_req,
   input  logic        dmem_ready,
   output logic        PC_Write,
   output logic        IFID_Write,
   output logic        hazard_detected,
   output logic        IF_Flush,
   output logic        pipe_freeze,
`ifdef PIPE_PERF_CNT_EN
   output logic [15:0] stall_cycles,
   output logic [15:0] flush_count,
`endif
   output logic        mem_error
);

   localparam logic [7:0] LP_TIMEOUT = 8'(MEM_TIMEOUT);

   logic [1:0] r_state;
   logic [1:0] w_state_nxt;
   logic [7:0] r_wait_cnt;
   logic [7:0] w_wait_cnt_nxt;
   logic       w_load_use;
   logic       w_freeze;

   load_use_detect u_load_use_detect (
      .i_idex_memread (IDEX_MemRead),
      .i_idex_rt      (IDEX_Rt),
      .i_ifid_rs      (IFID_Rs),
      .i_ifid_rt      (IFID_Rt),
      .o_load_use     (w_load_use)
   );

   // Freeze is raised in the same cycle the miss is seen and dropped the cycle ready arrives.
   always_comb begin
      w_freeze = 1'b0;
      if (!rst) begin
         case (r_state)
            ST_RUN:      w_freeze = dmem_req && !dmem_ready;
            ST_MEM_WAIT: w_freeze = !dmem_ready;
            ST_ERROR:    w_freeze = 1'b1;
            default:     w_freeze = 1'b0;
         endcase
      end
   end

   always_comb begin
      w_state_nxt    = r_state;
      w_wait_cnt_nxt = r_wait_cnt;
      case (r_state)
         ST_RUN: begin
            if (dmem_req && !dmem_ready) begin
               w_state_nxt    = ST_MEM_WAIT;
               w_wait_cnt_nxt = 8'd0;
            end
         end
         ST_MEM_WAIT: begin
            if (dmem_ready) begin
               w_state_nxt = ST_RUN;
            end else begin
               w_wait_cnt_nxt = r_wait_cnt + 8'd1;
               if (w_wait_cnt_nxt >= LP_TIMEOUT) w_state_nxt = ST_ERROR;
            end
         end
         ST_ERROR: w_state_nxt = ST_ERROR;
         default:  w_state_nxt = ST_RUN;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= ST_RUN;
         r_wait_cnt <= 8'd0;
      end else begin
         r_state    <= w_state_nxt;
         r_wait_cnt <= w_wait_cnt_nxt;
      end
   end

   always_comb begin
      PC_Write        = 1'b1;
      IFID_Write      = 1'b1;
      hazard_detected = 1'b0;
      IF_Flush        = 1'b0;
      if (!rst) begin
         if (w_freeze) begin
            PC_Write   = 1'b0;
            IFID_Write = 1'b0;
         end else if (w_load_use) begin
            // The branch in ID is simply re-evaluated once the bubble has gone through.
            PC_Write        = 1'b0;
            IFID_Write      = 1'b0;
            hazard_detected = 1'b1;
         end else if (branch_taken) begin
            IF_Flush = 1'b1;
         end
      end
   end

   assign pipe_freeze = w_freeze;
   assign mem_error   = (r_state == ST_ERROR);

`ifdef PIPE_PERF_CNT_EN
   logic [15:0] r_stall_cycles;
   logic [15:0] r_flush_count;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_stall_cycles <= 16'd0;
         r_flush_count  <= 16'd0;
      end else begin
         if (!PC_Write) r_stall_cycles <= sat_inc16(r_stall_cycles);
         if (IF_Flush)  r_flush_count  <= sat_inc16(r_flush_count);
      end
   end

   assign stall_cycles = r_stall_cycles;
   assign flush_count  = r_flush_count;
`endif

endmodule

// File: doc/pipeline_ctrl.md
PIPELINE_CTRL -- requirements
Module: pipeline_ctrl

Interface
REQ-001 SHALL have parameter MEM_TIMEOUT, default 16: maximum number of cycles spent in MEM_WAIT before entering ERROR (legal range 1..255).
REQ-002 SHALL have port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 SHALL have port IDEX_MemRead, input, 1 bit: the instruction in EX is LW.
REQ-005 SHALL have port IDEX_Rt, input, 5 bits: destination register of the LW in EX.
REQ-006 SHALL have ports IFID_Rs and IFID_Rt, input, 5 bits each: source registers of the instruction in ID.
REQ-007 SHALL have port branch_taken, input, 1 bit: the BEQ in ID resolves taken.
REQ-008 SHALL have ports dmem_req and dmem_ready, input, 1 bit each: data memory access active in MEM; data valid.
REQ-009 SHALL have outputs PC_Write and IFID_Write, 1 bit each: enables for the PC and IF/ID registers.
REQ-010 SHALL have outputs hazard_detected and IF_Flush, 1 bit each: bubble request to Control; squash of the IF/ID contents.
REQ-011 SHALL have output pipe_freeze, 1 bit: holds every pipeline register, including EX/MEM and MEM/WB.
REQ-012 SHALL have output mem_error, 1 bit: sticky memory timeout flag.

Function
REQ-013 SHALL implement an FSM with states RUN, MEM_WAIT and ERROR.
REQ-014 RUN -> MEM_WAIT SHALL occur when dmem_req=1 and dmem_ready=0.
REQ-015 MEM_WAIT -> RUN SHALL occur on dmem_ready=1.
REQ-016 MEM_WAIT -> ERROR SHALL occur when the wait counter reaches MEM_TIMEOUT.
REQ-017 ERROR SHALL be left only by rst.
REQ-018 pipe_freeze SHALL be combinational: 1 when (state=RUN and dmem_req and !dmem_ready), or (state=MEM_WAIT and !dmem_ready), or state=ERROR. This gives zero extra latency when dmem_ready arrives.
REQ-019 The wait counter (8-bit) SHALL clear on entry to MEM_WAIT and increment by one each cycle spent in MEM_WAIT.
REQ-020 load_use SHALL be 1 when IDEX_MemRead=1, IDEX_Rt!=0, and IDEX_Rt equals IFID_Rs or IFID_Rt.
REQ-021 Priority SHALL be pipe_freeze > load_use > branch_taken.
REQ-022 When frozen: PC_Write=0, IFID_Write=0, hazard_detected=0, IF_Flush=0.
REQ-023 When load_use and not frozen: PC_Write=0, IFID_Write=0, hazard_detected=1, IF_Flush=0 (branch deferred to the next cycle).
REQ-024 When branch_taken only: IF_Flush=1, PC_Write=1, IFID_Write=1.
REQ-025 Otherwise: PC_Write=1, IFID_Write=1, hazard_detected=0, IF_Flush=0.
REQ-026 mem_error SHALL be 1 exactly while state=ERROR.

Reset
REQ-027 On rst: state=RUN, wait counter=0, mem_error=0, performance counters=0. Reset overrides any stall, including a reset asserted mid-MEM_WAIT.
REQ-028 While rst=1, outputs SHALL be: PC_Write=1, IFID_Write=1, hazard_detected=0, IF_Flush=0, pipe_freeze=0.

Configuration
REQ-029 With PIPE_PERF_CNT_EN defined, the block SHALL add output stall_cycles (16 bits, counts cycles with PC_Write=0) and output flush_count (16 bits, counts cycles with IF_Flush=1). Both counters SHALL saturate at 0xFFFF.
REQ-030 Without PIPE_PERF_CNT_EN, those ports and counters SHALL be absent and all other behaviour SHALL be identical.

Structure
REQ-031 The state encoding (RUN=2'd0, MEM_WAIT=2'd1, ERROR=2'd2) and the MEM_TIMEOUT default SHALL reside in the shared package mips_pkg.
REQ-032 The load-use comparator SHALL be a sub-module named load_use_detect; the FSM and counters SHALL stay in pipeline_ctrl.

Verification
REQ-033 Bench SHALL cover: IDEX_MemRead=1, IDEX_Rt=5, IFID_Rs=5 -> hazard_detected=1, PC_Write=0 for one cycle; same stimulus with IDEX_Rt=0 -> no stall.
REQ-034 Bench SHALL cover: branch_taken=1 with no hazard -> IF_Flush=1, PC_Write=1; branch_taken with load_use -> IF_Flush=0, hazard_detected=1.
REQ-035 Bench SHALL cover: dmem_req=1, dmem_ready low for 3 cycles then high -> pipe_freeze=1 for exactly 3 cycles, RUN on the 4th.
REQ-036 Bench SHALL cover: MEM_TIMEOUT=4 with dmem_ready never asserted -> ERROR after 4 MEM_WAIT cycles, mem_error=1 and pipe_freeze=1 held until rst.
REQ-037 Bench SHALL cover: rst asserted during MEM_WAIT -> next cycle state=RUN, pipe_freeze=0, counters=0.
REQ-038 Bench SHALL cover, with PIPE_PERF_CNT_EN: 0x10000 stall cycles -> stall_cycles=0xFFFF, no wrap.
